// File: rtl/fpnew_result_reorder.sv
// Result reorder buffer for an out-of-order opgroup block.
// Issued ops get a slot tag, results land in any order, and writeback retires them in issue order.
module fpnew_result_reorder #(
  parameter  int unsigned Width    = 32,
  parameter  int unsigned Depth    = 4,
  parameter  int unsigned IdWidth  = 8,
  localparam int unsigned TagWidth = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [IdWidth-1:0]  issue_id_i,
  output logic                op_valid_o,
  input  logic                op_ready_i,
  output logic [TagWidth-1:0] op_tag_o,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic [TagWidth-1:0] res_tag_i,
  input  logic [Width-1:0]    res_data_i,
  input  logic [4:0]          res_status_i,
  input  logic                res_ext_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [Width-1:0]    wb_data_o,
  output logic [4:0]          wb_status_o,
  output logic                wb_ext_o,
  output logic [IdWidth-1:0]  wb_id_o,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [TagWidth:0]   count_o,
  output logic                err_o
);

  localparam logic [TagWidth:0] DepthCount = (TagWidth+1)'(Depth);

  logic [Depth-1:0]    alloc_q;
  logic [Depth-1:0]    done_q;
  logic [TagWidth-1:0] head_q;
  logic [TagWidth-1:0] tail_q;
  logic [TagWidth:0]   count_q;
  logic                err_q;

  logic [IdWidth-1:0]  id_q     [Depth];
  logic [Width-1:0]    data_q   [Depth];
  logic [4:0]          status_q [Depth];
  logic                ext_q    [Depth];

  logic do_alloc;
  logic do_capture;
  logic do_illegal;
  logic do_retire;

  // Full gating deliberately ignores a same-cycle retire: no slot bypass.
  assign op_valid_o    = issue_valid_i & (count_q < DepthCount) & ~flush_i;
  assign do_alloc      = op_valid_o & op_ready_i;
  assign issue_ready_o = do_alloc;
  assign op_tag_o      = tail_q;
  assign res_ready_o   = 1'b1;

  assign do_capture = res_valid_i & alloc_q[res_tag_i] & ~done_q[res_tag_i];
  assign do_illegal = res_valid_i & ~do_capture;

  assign wb_valid_o  = alloc_q[head_q] & done_q[head_q];
  assign do_retire   = wb_valid_o & wb_ready_i;
  assign wb_data_o   = data_q[head_q];
  assign wb_status_o = status_q[head_q];
  assign wb_ext_o    = ext_q[head_q];
  assign wb_id_o     = id_q[head_q];

  assign busy_o  = (count_q != '0);
  assign count_o = count_q;
  assign err_o   = err_q;

  // Control state; allocate, capture and retire always hit distinct slots.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= do_illegal;
      if (do_retire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TagWidth'(1);
      end
      if (do_capture) begin
        done_q[res_tag_i] <= 1'b1;
      end
      if (do_alloc) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + TagWidth'(1);
      end
      case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + (TagWidth+1)'(1);
        2'b01:   count_q <= count_q - (TagWidth+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot payloads are qualified by alloc/done, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      id_q[tail_q] <= issue_id_i;
    end
    if (do_capture) begin
      data_q[res_tag_i]   <= res_data_i;
      status_q[res_tag_i] <= res_status_i;
      ext_q[res_tag_i]    <= res_ext_i;
    end
  end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Directed self-checking bench for fpnew_result_reorder at default parameters.
module tb_fpnew_result_reorder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [7:0]  issue_id_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [1:0]  op_tag_o;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [1:0]  res_tag_i;
  logic [31:0] res_data_i;
  logic [4:0]  res_status_i;
  logic        res_ext_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_status_o;
  logic        wb_ext_o;
  logic [7:0]  wb_id_o;
  logic        flush_i;
  logic        busy_o;
  logic [2:0]  count_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  fpnew_result_reorder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_id_i    (issue_id_i),
    .op_valid_o    (op_valid_o),
    .op_ready_i    (op_ready_i),
    .op_tag_o      (op_tag_o),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_tag_i     (res_tag_i),
    .res_data_i    (res_data_i),
    .res_status_i  (res_status_i),
    .res_ext_i     (res_ext_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_data_o     (wb_data_o),
    .wb_status_o   (wb_status_o),
    .wb_ext_o      (wb_ext_o),
    .wb_id_o       (wb_id_o),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .count_o       (count_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0;
    issue_id_i    = '0;
    op_ready_i    = 1'b1;
    res_valid_i   = 1'b0;
    res_tag_i     = '0;
    res_data_i    = '0;
    res_status_i  = '0;
    res_ext_i     = 1'b0;
    wb_ready_i    = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic issue_one(input logic [7:0] id);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic result_one(input logic [1:0] tag, input logic [31:0] data,
                            input logic [4:0] status, input logic ext);
    res_valid_i  = 1'b1;
    res_tag_i    = tag;
    res_data_i   = data;
    res_status_i = status;
    res_ext_i    = ext;
    step();
    res_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({wb_valid_o, busy_o, count_o, err_o, op_tag_o, res_ready_o} !== {1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: wb_valid=%b busy=%b count=%0d err=%b tag=%0d res_ready=%b required 0 0 0 0 0 1",
               wb_valid_o, busy_o, count_o, err_o, op_tag_o, res_ready_o);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    issue_valid_i = 1'b1;
    issue_id_i    = 8'h10;
    #1;
    checks++;
    if ({op_valid_o, issue_ready_o, op_tag_o} !== {1'b1, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL inorder_issue0: valid=%b ready=%b tag=%0d required 1 1 0", op_valid_o, issue_ready_o, op_tag_o);
    end
    step();
    issue_id_i = 8'h11;
    #1;
    checks++;
    if (op_tag_o !== 2'd1) begin
      failures++;
      $display("FAIL inorder_issue1_tag: got %0d required 1", op_tag_o);
    end
    step();
    issue_valid_i = 1'b0;
    res_valid_i = 1'b1;
    res_tag_i   = 2'd0;
    res_data_i  = 32'h0000_0055;
    #1;
    checks++;
    if (wb_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL inorder_wb_early: wb_valid=%b required 0", wb_valid_o);
    end
    step();
    res_tag_i  = 2'd1;
    res_data_i = 32'h0000_0066;
    wb_ready_i = 1'b1;
    #1;
    checks++;
    if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 8'h10, 32'h55}) begin
      failures++;
      $display("FAIL inorder_wb0: valid=%b id=%h data=%h required 1 10 00000055", wb_valid_o, wb_id_o, wb_data_o);
    end
    step();
    res_valid_i = 1'b0;
    #1;
    checks++;
    if ({wb_valid_o, wb_id_o, wb_data_o, count_o} !== {1'b1, 8'h11, 32'h66, 3'd1}) begin
      failures++;
      $display("FAIL inorder_wb1: valid=%b id=%h data=%h count=%0d required 1 11 00000066 1",
               wb_valid_o, wb_id_o, wb_data_o, count_o);
    end
    step();
    wb_ready_i = 1'b0;
    #1;
    checks++;
    if ({wb_valid_o, busy_o, count_o} !== {1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL inorder_drained: wb_valid=%b busy=%b count=%0d required 0 0 0", wb_valid_o, busy_o, count_o);
    end
  endtask

  task automatic test_out_of_order();
    logic [7:0]  exp_id   [3] = '{8'hA0, 8'hA1, 8'hA2};
    logic [31:0] exp_data [3] = '{32'h1, 32'h2, 32'h3};
    logic [4:0]  exp_st   [3] = '{5'h01, 5'h10, 5'h04};
    logic        exp_ext  [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    issue_one(8'hA0);
    issue_one(8'hA1);
    issue_one(8'hA2);
    result_one(2'd2, 32'h3, 5'h04, 1'b0);
    #1;
    checks++;
    if (wb_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL ooo_head_blocked: wb_valid=%b required 0", wb_valid_o);
    end
    result_one(2'd0, 32'h1, 5'h01, 1'b0);
    result_one(2'd1, 32'h2, 5'h10, 1'b1);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o, wb_status_o, wb_ext_o} !==
          {1'b1, exp_id[i], exp_data[i], exp_st[i], exp_ext[i]}) begin
        failures++;
        $display("FAIL ooo_wb%0d: valid=%b id=%h data=%h st=%h ext=%b required 1 %h %h %h %b", i,
                 wb_valid_o, wb_id_o, wb_data_o, wb_status_o, wb_ext_o,
                 exp_id[i], exp_data[i], exp_st[i], exp_ext[i]);
      end
      step();
    end
    wb_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0) begin
      failures++;
      $display("FAIL ooo_count_end: got %0d required 0", count_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) result_one(2'(i), 32'h100 + 32'(i), 5'h0, 1'b0);
    issue_valid_i = 1'b1;
    issue_id_i    = 8'h24;
    #1;
    checks++;
    if ({count_o, op_valid_o, issue_ready_o, wb_valid_o} !== {3'd4, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL full_stalled: count=%0d op_valid=%b ready=%b wb_valid=%b required 4 0 0 1",
               count_o, op_valid_o, issue_ready_o, wb_valid_o);
    end
    step();
    wb_ready_i = 1'b1;
    #1;
    checks++;
    if ({issue_ready_o, wb_id_o} !== {1'b0, 8'h20}) begin
      failures++;
      $display("FAIL full_no_bypass: ready=%b wb_id=%h required 0 20", issue_ready_o, wb_id_o);
    end
    step();
    wb_ready_i = 1'b0;
    #1;
    checks++;
    if ({issue_ready_o, op_tag_o, count_o} !== {1'b1, 2'd0, 3'd3}) begin
      failures++;
      $display("FAIL full_after_retire: ready=%b tag=%0d count=%0d required 1 0 3", issue_ready_o, op_tag_o, count_o);
    end
    step();
    issue_valid_i = 1'b0;
    #1;
    checks++;
    if ({count_o, wb_id_o} !== {3'd4, 8'h21}) begin
      failures++;
      $display("FAIL full_refilled: count=%0d wb_id=%h required 4 21", count_o, wb_id_o);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    issue_one(8'h40);
    result_one(2'd3, 32'hDEAD, 5'h1F, 1'b1);
    #1;
    checks++;
    if ({err_o, count_o, wb_valid_o} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL illegal_unalloc: err=%b count=%0d wb_valid=%b required 1 1 0", err_o, count_o, wb_valid_o);
    end
    step();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse_width: err=%b required 0", err_o);
    end
    result_one(2'd0, 32'h0000_1234, 5'h02, 1'b0);
    #1;
    checks++;
    if ({err_o, wb_valid_o, wb_data_o} !== {1'b0, 1'b1, 32'h1234}) begin
      failures++;
      $display("FAIL illegal_legal_result: err=%b wb_valid=%b data=%h required 0 1 00001234", err_o, wb_valid_o, wb_data_o);
    end
    result_one(2'd0, 32'h0000_9999, 5'h1F, 1'b1);
    #1;
    checks++;
    if ({err_o, wb_data_o, wb_status_o, wb_ext_o} !== {1'b1, 32'h1234, 5'h02, 1'b0}) begin
      failures++;
      $display("FAIL illegal_duplicate: err=%b data=%h st=%h ext=%b required 1 00001234 02 0",
               err_o, wb_data_o, wb_status_o, wb_ext_o);
    end
    step();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_dup_pulse_width: err=%b required 0", err_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_one(8'h50);
    issue_one(8'h51);
    issue_one(8'h52);
    result_one(2'd0, 32'h7, 5'h0, 1'b0);
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    issue_id_i    = 8'h53;
    res_valid_i   = 1'b1;
    res_tag_i     = 2'd3;
    #1;
    checks++;
    if ({op_valid_o, issue_ready_o} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_gate: op_valid=%b ready=%b required 0 0", op_valid_o, issue_ready_o);
    end
    step();
    flush_i     = 1'b0;
    res_valid_i = 1'b0;
    #1;
    checks++;
    if ({count_o, busy_o, wb_valid_o, err_o, op_tag_o, issue_ready_o} !== {3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush_after: count=%0d busy=%b wb_valid=%b err=%b tag=%0d ready=%b required 0 0 0 0 0 1",
               count_o, busy_o, wb_valid_o, err_o, op_tag_o, issue_ready_o);
    end
    step();
    issue_valid_i = 1'b0;
    result_one(2'd1, 32'h8, 5'h0, 1'b0);
    #1;
    checks++;
    if ({err_o, wb_valid_o} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flush_stale_tag: err=%b wb_valid=%b required 1 0", err_o, wb_valid_o);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_tag;
    do_reset();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_tag = 2'(i % 4);
      issue_valid_i = 1'b1;
      issue_id_i    = 8'h30 + 8'(i);
      #1;
      checks++;
      if ({issue_ready_o, op_tag_o} !== {1'b1, exp_tag}) begin
        failures++;
        $display("FAIL wrap_tag%0d: ready=%b tag=%0d required 1 %0d", i, issue_ready_o, op_tag_o, exp_tag);
      end
      step();
      issue_valid_i = 1'b0;
      result_one(exp_tag, 32'(i), 5'h0, 1'b0);
      #1;
      checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 8'h30 + 8'(i), 32'(i)}) begin
        failures++;
        $display("FAIL wrap_wb%0d: valid=%b id=%h data=%h required 1 %h %h", i,
                 wb_valid_o, wb_id_o, wb_data_o, 8'h30 + 8'(i), 32'(i));
      end
      step();
    end
    wb_ready_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, op_tag_o} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL wrap_end: busy=%b tag=%0d required 0 2", busy_o, op_tag_o);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    issue_one(8'h60);
    issue_one(8'h61);
    do_reset();
    #1;
    checks++;
    if ({count_o, busy_o} !== {3'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_state: count=%0d busy=%b required 0 0", count_o, busy_o);
    end
    result_one(2'd1, 32'h5, 5'h0, 1'b0);
    #1;
    checks++;
    if ({err_o, wb_valid_o} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midreset_stale_tag: err=%b wb_valid=%b required 1 0", err_o, wb_valid_o);
    end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full();
    test_illegal();
    test_flush();
    test_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpnew_result_reorder.md
FPNEW_RESULT_REORDER -- requirements
Module: fpnew_result_reorder

Interface
REQ-001 Parameter Width: default 32; result data width in bits.
REQ-002 Parameter Depth: default 4; number of reorder slots; power of two, at least 2.
REQ-003 Parameter IdWidth: default 8; width of the issuer-supplied operation ID.
REQ-004 Localparam TagWidth: $clog2(Depth); width of the slot tag.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 issue_valid_i  in  1  issuer presents an operation.
REQ-008 issue_ready_o  out  1  operation accepted this cycle.
REQ-009 issue_id_i  in  IdWidth  issuer ID of the operation.
REQ-010 op_valid_o  out  1  operation forwarded to the opgroup block.
REQ-011 op_ready_i  in  1  opgroup block accepts the operation.
REQ-012 op_tag_o  out  TagWidth  slot tag attached to the forwarded operation.
REQ-013 res_valid_i  in  1  opgroup result valid; results may return out of order.
REQ-014 res_ready_o  out  1  result accepted; tied to 1.
REQ-015 res_tag_i  in  TagWidth  slot tag returned with the result.
REQ-016 res_data_i  in  Width  result value.
REQ-017 res_status_i  in  5  fpnew status flags (NV, DZ, OF, UF, NX).
REQ-018 res_ext_i  in  1  extension bit.
REQ-019 wb_valid_o  out  1  in-order writeback valid.
REQ-020 wb_ready_i  in  1  writeback consumer ready.
REQ-021 wb_data_o, wb_status_o, wb_ext_o, wb_id_o  out  Width/5/1/IdWidth  head-slot contents.
REQ-022 flush_i  in  1  kill all in-flight operations; asserted in the same cycle as the opgroup flush.
REQ-023 busy_o  out  1  at least one slot allocated.
REQ-024 count_o  out  TagWidth+1  number of allocated slots.
REQ-025 err_o  out  1  one-cycle pulse on a result with an unallocated or already-done tag.

Function
REQ-026 The block keeps a circular buffer of Depth slots with registered fields: alloc, done, id, data, status, ext.
- Tail pointer tail marks the next slot to allocate.
- Head pointer head marks the oldest slot, which is the next to retire.
- Counter count tracks allocated slots.
REQ-027 Issue gating: op_valid_o = issue_valid_i & (count<Depth) & !flush_i; issue_ready_o = op_valid_o & op_ready_i; op_tag_o = tail.
REQ-028 Allocation on issue_ready_o: slot[tail] gets alloc=1, done=0, id=issue_id_i; tail increments modulo Depth.
REQ-029 Full condition: when count==Depth, op_valid_o=0 even if a retire occurs in the same cycle; there is no same-cycle slot bypass.
REQ-030 Result capture when res_valid_i is high and slot[res_tag_i] has alloc=1 and done=0: store data/status/ext and set done=1.
REQ-031 Result with alloc=0 or done=1: the result is dropped, no state changes, and err_o pulses on the next cycle.
REQ-032 Writeback outputs are driven from registers only:
- wb_valid_o = slot[head].alloc & slot[head].done.
- wb_* fields come from slot[head].
- Minimum latency from result capture to wb_valid_o is 1 cycle.
REQ-033 Retire on wb_valid_o & wb_ready_i: slot[head] gets alloc=0 and done=0; head increments modulo Depth.
REQ-034 wb_* fields hold stable while wb_valid_o=1 and wb_ready_i=0.
REQ-035 count update: +1 on allocate, -1 on retire, unchanged when both occur in the same cycle.
REQ-036 Simultaneous allocate, result capture and retire in one cycle are all performed; they touch distinct slot fields.
REQ-037 Flush has priority over allocate, capture and retire in the same cycle:
- all alloc/done bits clear;
- head=tail=count=0;
- err_o does not pulse for results arriving during the flush cycle.
REQ-038 busy_o = (count!=0); count_o = count.

Reset
REQ-039 On rst_i high at a clock edge, all state clears:
- head=0, tail=0, count=0;
- all alloc/done bits clear;
- wb_valid_o=0, busy_o=0, count_o=0, err_o=0.
REQ-040 Slot payload registers (data/status/ext/id) need no reset.
REQ-041 Reset mid-operation discards all outstanding slots; results arriving after reset for pre-reset tags pulse err_o.

Verification
REQ-042 In-order return:
- Stimulus: issue IDs 0x10, 0x11; results for tag 0 then tag 1.
- Required response: wb_id_o 0x10 then 0x11; wb_valid_o first rises 1 cycle after the tag-0 result.
REQ-043 Out-of-order return:
- Stimulus: issue 0xA0, 0xA1, 0xA2; results for tag 2, tag 0, tag 1, with data 0x3, 0x1, 0x2.
- Required response: writeback order 0xA0/0x1, 0xA1/0x2, 0xA2/0x3.
REQ-044 Full with stalled writeback:
- Stimulus: Depth=4; issue 4 operations; hold wb_ready_i=0; return all results.
- Required response: count_o=4, issue_ready_o=0; the fifth issue is accepted only the cycle after the first retire.
REQ-045 Illegal result:
- Stimulus: a result on an unallocated tag 3 with count_o=1.
- Required response: err_o pulses for 1 cycle; no state changes.
- Stimulus: a duplicate result on an already-done tag.
- Required response: err_o pulses for 1 cycle.
REQ-046 Flush:
- Stimulus: 3 operations outstanding; flush_i asserted together with an issue request and a result.
- Required response: next cycle count_o=0, busy_o=0, wb_valid_o=0; the next issue receives op_tag_o=0.
REQ-047 Wrap-around:
- Stimulus: 10 issue/retire pairs at Depth=4.
- Required response: op_tag_o sequence 0,1,2,3,0,1,...; IDs retire in issue order.
